// File: rtl/alu_op_sequencer_if.sv
// Handshake and control bundle between the instruction
// source, the ALU microsequencer and the datapath.
interface alu_op_sequencer_if;
  logic       InstrValid;
  logic       InstrReady;
  logic [1:0] InstructionCode;
  logic       R1in;
  logic       R1out;
  logic       R2in;
  logic       R2out;
  logic       Add;
  logic       Sub;
  logic       Mul;
  logic       Div;
  logic       SelectY;
  logic       Yin;
  logic       Zin;
  logic       Zout;
  logic       Done;
  logic       Busy;

  modport master (
    output InstrValid, InstructionCode,
    input  InstrReady,
    input  R1in, R1out, R2in, R2out,
    input  Add, Sub, Mul, Div,
    input  SelectY, Yin, Zin, Zout,
    input  Done, Busy
  );

  modport slave (
    input  InstrValid, InstructionCode,
    output InstrReady,
    output R1in, R1out, R2in, R2out,
    output Add, Sub, Mul, Div,
    output SelectY, Yin, Zin, Zout,
    output Done, Busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Hardwired Moore microsequencer for the single-bus
// R1/R2/Y/Z datapath: R1 <- R1 op R2 per accepted instruction.
module alu_op_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input logic Clock,
  input logic Reset,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_Y,
    EXEC,
    WRITE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MULDIV_CYCLES - 1);

  state_t           st_q, st_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic             last;

  assign bus.InstrReady = (st_q == IDLE) & ~Reset;
  assign acc  = bus.InstrValid & bus.InstrReady;
  // Add/Sub finish in one EXEC cycle; Mul/Div run to LAST
  assign last = ~op_q[1] | (cnt_q == LAST);

  // State, latched opcode and execute counter registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st_q  <= IDLE;
      op_q  <= 2'b00;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state, opcode latch and counter update
  always_comb begin
    st_d  = st_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (acc) begin
          st_d = LOAD_Y;
          op_d = bus.InstructionCode;
        end
      end
      LOAD_Y: begin
        st_d  = EXEC;
        cnt_d = '0;
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (last) st_d = WRITE;
      end
      WRITE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Moore output decode from state and latched opcode
  always_comb begin
    bus.R1in    = 1'b0;
    bus.R1out   = 1'b0;
    bus.R2in    = 1'b0;
    bus.R2out   = 1'b0;
    bus.Add     = 1'b0;
    bus.Sub     = 1'b0;
    bus.Mul     = 1'b0;
    bus.Div     = 1'b0;
    bus.SelectY = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zout    = 1'b0;
    bus.Done    = 1'b0;
    bus.Busy    = (st_q != IDLE);
    unique case (1'b1)
      (st_q == LOAD_Y): begin
        bus.R1out = 1'b1;
        bus.Yin   = 1'b1;
      end
      (st_q == EXEC): begin
        bus.R2out   = 1'b1;
        bus.SelectY = 1'b1;
        bus.Zin     = last;
        bus.Add     = (op_q == 2'b00);
        bus.Sub     = (op_q == 2'b01);
        bus.Mul     = (op_q == 2'b10);
        bus.Div     = (op_q == 2'b11);
      end
      (st_q == WRITE): begin
        bus.Zout = 1'b1;
        bus.R1in = 1'b1;
        bus.Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer,
// two instances (4-cycle and 1-cycle Mul/Div).
module tb_alu_op_sequencer;

  localparam bit [13:0] M_R1IN  = 14'h2000;
  localparam bit [13:0] M_R1OUT = 14'h1000;
  localparam bit [13:0] M_R2OUT = 14'h0400;
  localparam bit [13:0] M_ADD   = 14'h0200;
  localparam bit [13:0] M_SUB   = 14'h0100;
  localparam bit [13:0] M_MUL   = 14'h0080;
  localparam bit [13:0] M_DIV   = 14'h0040;
  localparam bit [13:0] M_SELY  = 14'h0020;
  localparam bit [13:0] M_YIN   = 14'h0010;
  localparam bit [13:0] M_ZIN   = 14'h0008;
  localparam bit [13:0] M_ZOUT  = 14'h0004;
  localparam bit [13:0] M_DONE  = 14'h0002;
  localparam bit [13:0] M_BUSY  = 14'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] code;

  int cmp  = 0;
  int mism = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  alu_op_sequencer_if if4 ();
  alu_op_sequencer_if if1 ();

  assign if4.InstrValid      = valid;
  assign if4.InstructionCode = code;
  assign if1.InstrValid      = valid;
  assign if1.InstructionCode = code;

  alu_op_sequencer #(.MULDIV_CYCLES(4), .CNT_W(3)) dut4 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if4.slave)
  );

  alu_op_sequencer #(.MULDIV_CYCLES(1), .CNT_W(1)) dut1 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  wire [13:0] v4 = {if4.R1in, if4.R1out, if4.R2in,
    if4.R2out, if4.Add, if4.Sub, if4.Mul, if4.Div,
    if4.SelectY, if4.Yin, if4.Zin, if4.Zout,
    if4.Done, if4.Busy};
  wire [13:0] v1 = {if1.R1in, if1.R1out, if1.R2in,
    if1.R2out, if1.Add, if1.Sub, if1.Mul, if1.Div,
    if1.SelectY, if1.Yin, if1.Zin, if1.Zout,
    if1.Done, if1.Busy};

  // Reference model: per instance, whether an instruction
  // is in flight, its opcode and its cycle position
  // (0 = operand load, 1..n = execute, n+1 = writeback).
  bit       act [2];
  bit [1:0] cd  [2];
  int       pos [2];
  int       nn  [2] = '{4, 1};

  function automatic bit [13:0] opm(input bit [1:0] c);
    case (c)
      2'd0:    return M_ADD;
      2'd1:    return M_SUB;
      2'd2:    return M_MUL;
      default: return M_DIV;
    endcase
  endfunction

  function automatic bit [13:0] word(input int d);
    int n;
    n = cd[d][1] ? nn[d] : 1;
    if (!act[d]) return 14'h0;
    if (pos[d] == 0)
      return M_R1OUT | M_YIN | M_BUSY;
    if (pos[d] <= n)
      return M_R2OUT | M_SELY | opm(cd[d]) | M_BUSY
        | ((pos[d] == n) ? M_ZIN : 14'h0);
    return M_ZOUT | M_R1IN | M_DONE | M_BUSY;
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    cmp++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h",
        tag, got, exp);
    end
  endtask

  task automatic step();
    int n;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      n = cd[d][1] ? nn[d] : 1;
      if (rst) begin
        act[d] = 1'b0;
      end else if (act[d]) begin
        pos[d]++;
        if (pos[d] > n + 1) act[d] = 1'b0;
      end else if (valid) begin
        act[d] = 1'b1;
        cd[d]  = code;
        pos[d] = 0;
        if (d == 0) acc_cnt++;
      end
    end
    #1;
    chk("outs4", 16'(v4), 16'(word(0)));
    chk("outs1", 16'(v1), 16'(word(1)));
    chk("ready4", 16'(if4.InstrReady),
      16'(!act[0] && !rst));
    chk("ready1", 16'(if1.InstrReady),
      16'(!act[1] && !rst));
    chk("r2in", 16'(if4.R2in), 16'h0);
    chk("onehot", 16'($countones({if4.Add, if4.Sub,
      if4.Mul, if4.Div}) <= 1), 16'h1);
    chk("busexcl", 16'($countones({if4.R1out,
      if4.R2out, if4.Zout}) <= 1), 16'h1);
    if (if4.Done) done_cnt++;
  endtask

  // Steps until the chosen instance pulses Done; k counts
  // cycles after the accept edge (1 = operand load cycle).
  task automatic lat(input string tag, input int d,
                     input int exp);
    int k;
    k = 1;
    while (!(d == 0 ? if4.Done : if1.Done) && k < 20) begin
      step();
      k++;
    end
    chk(tag, 16'(k), 16'(exp));
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    valid = 1'b1;
    code = 2'b00;
    step();
    step();
    rst = 1'b0;
    valid = 1'b0;
    step();

    // Add
    valid = 1'b1;
    code = 2'b00;
    step();
    valid = 1'b0;
    lat("lat_add", 0, 3);
    step();
    step();

    // Mul on 4-cycle instance
    valid = 1'b1;
    code = 2'b10;
    step();
    valid = 1'b0;
    lat("lat_mul4", 0, 6);
    repeat (3) step();

    // Div on 1-cycle instance
    valid = 1'b1;
    code = 2'b11;
    step();
    valid = 1'b0;
    lat("lat_div1", 1, 3);
    repeat (6) step();

    // Back-to-back Sub then Div, code changes while busy
    valid = 1'b1;
    code = 2'b01;
    step();
    code = 2'b10;
    step();
    step();
    code = 2'b11;
    repeat (14) step();
    valid = 1'b0;
    repeat (8) step();

    // Reset in second Mul execute cycle
    valid = 1'b1;
    code = 2'b10;
    step();
    valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_outs", 16'(v4), 16'h0);
    rst = 1'b0;
    step();
    chk("rst_ready", 16'(if4.InstrReady), 16'h1);
    valid = 1'b1;
    code = 2'b00;
    step();
    valid = 1'b0;
    lat("lat_add2", 0, 3);
    repeat (3) step();

    // Random run
    acc_cnt = 0;
    done_cnt = 0;
    cyc = 0;
    while (acc_cnt < 500 && cyc < 20000) begin
      valid = ($urandom_range(0, 2) != 0);
      code = 2'($urandom);
      step();
      cyc++;
    end
    valid = 1'b0;
    repeat (10) step();
    chk("rand_acc", 16'(acc_cnt), 16'd500);
    chk("done_eq_acc", 16'(done_cnt), 16'(acc_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      cmp, mism);
    $finish;
  end

endmodule
